fetch_stage: RTL and testbench

Instruction-fetch stage of the 64-bit RISC-V pipeline. Owns the program counter and issues one instruction-memory request at a time over a req/gnt/rvalid handshake. Fills the IF/ID pipeline register, honouring stalls from the hazard unit. Consumes the taken decision and target produced by the EX-stage branch unit, redirects the PC and flushes wrong-path instructions.

---
 rtl/fetch_pkg.sv | 16 +
 rtl/fetch_hold_buffer.sv | 37 +++
 rtl/fetch_stage.sv | 168 ++++++++++++++++
 tb/tb_fetch_stage.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

   localparam int unsigned XLEN = 64;
   localparam int unsigned ILEN = 32;

   localparam logic [ILEN-1:0] NOP_INSTR = 32'h00000013;

   typedef enum logic [1:0] {
      S_REQ   = 2'd0,
      S_WAIT  = 2'd1,
      S_DRAIN = 2'd2,
      S_HOLD  = 2'd3
   } fetch_state_e;

endpackage

// File: rtl/fetch_hold_buffer.sv
// One-entry pc+instr holding register for a response that arrives while IF/ID is stalled.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   load                capture load_pc/load_instr, set valid
//   clear               drop the entry (wins over load)
//   load_pc, load_instr data to capture
//   valid, pc, instr    registered entry contents
module fetch_hold_buffer
   import fetch_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            load,
   input  logic            clear,
   input  logic [XLEN-1:0] load_pc,
   input  logic [ILEN-1:0] load_instr,
   output logic            valid,
   output logic [XLEN-1:0] pc,
   output logic [ILEN-1:0] instr
);

   // Entry register; clear has priority so a redirect always empties it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid <= 1'b0;
         pc    <= '0;
         instr <= NOP_INSTR;
      end else if (clear) begin
         valid <= 1'b0;
      end else if (load) begin
         valid <= 1'b1;
         pc    <= load_pc;
         instr <= load_instr;
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues one imem request at a time over
// req/gnt/rvalid, fills the IF/ID register under hazard stalls and applies
// EX-stage redirects, discarding wrong-path responses.
// Ports:
//   clk, rst_n                          clock, async active-low reset
//   stall_i                             hold IF/ID
//   br_taken_i, br_target_i             redirect request and target
//   imem_req_o, imem_addr_o             request valid / address (PC)
//   imem_gnt_i, imem_rvalid_i,
//   imem_rdata_i                        memory handshake and response word
//   if_id_valid_o, if_id_pc_o,
//   if_id_instr_o                       IF/ID pipeline register
module fetch_stage
   import fetch_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = 64'h0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            stall_i,
   input  logic            br_taken_i,
   input  logic [XLEN-1:0] br_target_i,
   output logic            imem_req_o,
   output logic [XLEN-1:0] imem_addr_o,
   input  logic            imem_gnt_i,
   input  logic            imem_rvalid_i,
   input  logic [ILEN-1:0] imem_rdata_i,
   output logic            if_id_valid_o,
   output logic [XLEN-1:0] if_id_pc_o,
   output logic [ILEN-1:0] if_id_instr_o
);

   fetch_state_e    state_q, state_d;
   logic [XLEN-1:0] pc_q;
   logic [XLEN-1:0] req_pc_q;
   logic [XLEN-1:0] target_aligned;

   logic            gnt;
   logic            accept;
   logic            buf_load;
   logic            buf_clear;
   logic            ifid_load_mem;
   logic            ifid_load_buf;

   logic            buf_valid;
   logic [XLEN-1:0] buf_pc;
   logic [ILEN-1:0] buf_instr;

   // A grant only counts against a request we are actually presenting.
   assign gnt            = imem_gnt_i & imem_req_o;
   assign target_aligned = {br_target_i[XLEN-1:2], 2'b00};
   assign imem_addr_o    = pc_q;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_REQ;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state and datapath controls; a redirect overrides every other event.
   always_comb begin
      state_d       = state_q;
      accept        = 1'b0;
      buf_load      = 1'b0;
      buf_clear     = 1'b0;
      ifid_load_mem = 1'b0;
      ifid_load_buf = 1'b0;
      unique case (state_q)
         S_REQ: begin
            if (br_taken_i) begin
               // A grant in the redirect cycle leaves a response in flight.
               state_d = gnt ? S_DRAIN : S_REQ;
            end else if (gnt) begin
               accept  = 1'b1;
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (br_taken_i) begin
               state_d = imem_rvalid_i ? S_REQ : S_DRAIN;
            end else if (imem_rvalid_i) begin
               if (stall_i) begin
                  buf_load = 1'b1;
                  state_d  = S_HOLD;
               end else begin
                  ifid_load_mem = 1'b1;
                  state_d       = S_REQ;
               end
            end
         end
         S_DRAIN: begin
            if (imem_rvalid_i) begin
               state_d = S_REQ;
            end
         end
         S_HOLD: begin
            if (br_taken_i) begin
               buf_clear = 1'b1;
               state_d   = S_REQ;
            end else if (!stall_i) begin
               ifid_load_buf = buf_valid;
               buf_clear     = 1'b1;
               state_d       = S_REQ;
            end
         end
         default: state_d = S_REQ;
      endcase
   end

   // Request valid is registered from the next state so it stays low during reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         imem_req_o <= 1'b0;
      end else begin
         imem_req_o <= (state_d == S_REQ);
      end
   end

   // PC and outstanding-request address.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q     <= RESET_PC;
         req_pc_q <= '0;
      end else if (br_taken_i) begin
         pc_q <= target_aligned;
      end else if (accept) begin
         req_pc_q <= pc_q;
         pc_q     <= pc_q + XLEN'(4);
      end
   end

   // IF/ID register: redirect kills, stall holds, otherwise load or bubble.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         if_id_valid_o <= 1'b0;
         if_id_pc_o    <= '0;
         if_id_instr_o <= NOP_INSTR;
      end else if (br_taken_i) begin
         if_id_valid_o <= 1'b0;
      end else if (ifid_load_mem) begin
         if_id_valid_o <= 1'b1;
         if_id_pc_o    <= req_pc_q;
         if_id_instr_o <= imem_rdata_i;
      end else if (ifid_load_buf) begin
         if_id_valid_o <= 1'b1;
         if_id_pc_o    <= buf_pc;
         if_id_instr_o <= buf_instr;
      end else if (!stall_i) begin
         if_id_valid_o <= 1'b0;
      end
   end

   fetch_hold_buffer u_hold_buffer (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (buf_load),
      .clear      (buf_clear),
      .load_pc    (req_pc_q),
      .load_instr (imem_rdata_i),
      .valid      (buf_valid),
      .pc         (buf_pc),
      .instr      (buf_instr)
   );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage; the bench plays the instruction memory cycle by cycle.
module tb_fetch_stage;

   localparam logic [63:0] RST_PC = 64'h1000;
   localparam logic [31:0] NOP    = 32'h00000013;
   localparam logic [31:0] I0     = 32'h00000093;
   localparam logic [31:0] I1     = 32'h00100113;
   localparam logic [31:0] I2     = 32'h00200193;
   localparam logic [31:0] I3     = 32'h00300213;
   localparam logic [31:0] I4     = 32'h00400293;
   localparam logic [31:0] BAD    = 32'hDEADBEEF;

   logic        clk;
   logic        rst_n;
   logic        stall_i;
   logic        br_taken_i;
   logic [63:0] br_target_i;
   logic        imem_req_o;
   logic [63:0] imem_addr_o;
   logic        imem_gnt_i;
   logic        imem_rvalid_i;
   logic [31:0] imem_rdata_i;
   logic        if_id_valid_o;
   logic [63:0] if_id_pc_o;
   logic [31:0] if_id_instr_o;

   int total;
   int bad;

   fetch_stage #(.RESET_PC(RST_PC)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .stall_i       (stall_i),
      .br_taken_i    (br_taken_i),
      .br_target_i   (br_target_i),
      .imem_req_o    (imem_req_o),
      .imem_addr_o   (imem_addr_o),
      .imem_gnt_i    (imem_gnt_i),
      .imem_rvalid_i (imem_rvalid_i),
      .imem_rdata_i  (imem_rdata_i),
      .if_id_valid_o (if_id_valid_o),
      .if_id_pc_o    (if_id_pc_o),
      .if_id_instr_o (if_id_instr_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic gnt, input logic rv, input logic [31:0] rd,
                        input logic st, input logic br, input logic [63:0] tgt);
      imem_gnt_i    = gnt;
      imem_rvalid_i = rv;
      imem_rdata_i  = rd;
      stall_i       = st;
      br_taken_i    = br;
      br_target_i   = tgt;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
      tick(); tick();
      total++; if (imem_req_o !== 1'b0) begin bad++; $display("FAIL rst_req got=%b exp=0", imem_req_o); end
      total++; if (if_id_valid_o !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", if_id_valid_o); end
      total++; if (if_id_pc_o !== 64'h0) begin bad++; $display("FAIL rst_pc got=%h exp=0", if_id_pc_o); end
      total++; if (if_id_instr_o !== NOP) begin bad++; $display("FAIL rst_instr got=%h exp=%h", if_id_instr_o, NOP); end
      total++; if (imem_addr_o !== RST_PC) begin bad++; $display("FAIL rst_addr got=%h exp=%h", imem_addr_o, RST_PC); end
      rst_n = 1'b1;
      #2;
      total++; if (imem_req_o !== 1'b0) begin bad++; $display("FAIL rel_req_early got=%b exp=0", imem_req_o); end
      tick();
      total++; if (imem_req_o !== 1'b1) begin bad++; $display("FAIL rel_req got=%b exp=1", imem_req_o); end
      total++; if (imem_addr_o !== 64'h1000) begin bad++; $display("FAIL rel_addr got=%h exp=1000", imem_addr_o); end
   endtask

   // Two back-to-back fetches at 0x1000 and 0x1004 with immediate gnt and rvalid+1.
   task automatic test_back_to_back();
      logic [31:0] words [2];
      words[0] = I0;
      words[1] = I1;
      for (int k = 0; k < 2; k++) begin
         drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
         tick();
         total++; if (imem_req_o !== 1'b0) begin bad++; $display("FAIL seq_req_low[%0d] got=%b exp=0", k, imem_req_o); end
         total++; if (if_id_valid_o !== 1'b0) begin bad++; $display("FAIL seq_bubble[%0d] got=%b exp=0", k, if_id_valid_o); end
         drive(1'b0, 1'b1, words[k], 1'b0, 1'b0, 64'h0);
         tick();
         total++; if (if_id_valid_o !== 1'b1) begin bad++; $display("FAIL seq_valid[%0d] got=%b exp=1", k, if_id_valid_o); end
         total++; if (if_id_pc_o !== 64'h1000 + 64'(4 * k)) begin bad++; $display("FAIL seq_pc[%0d] got=%h exp=%h", k, if_id_pc_o, 64'h1000 + 64'(4 * k)); end
         total++; if (if_id_instr_o !== words[k]) begin bad++; $display("FAIL seq_instr[%0d] got=%h exp=%h", k, if_id_instr_o, words[k]); end
         total++; if (imem_req_o !== 1'b1) begin bad++; $display("FAIL seq_req_next[%0d] got=%b exp=1", k, imem_req_o); end
         total++; if (imem_addr_o !== 64'h1004 + 64'(4 * k)) begin bad++; $display("FAIL seq_addr[%0d] got=%h exp=%h", k, imem_addr_o, 64'h1004 + 64'(4 * k)); end
      end
   endtask

   // Stall for 3 cycles across the 0x1008 fetch; IF/ID keeps 0x1004 until release.
   task automatic test_stall();
      drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 64'h0);
      tick();
      drive(1'b0, 1'b1, I2, 1'b1, 1'b0, 64'h0);
      tick();
      for (int k = 0; k < 2; k++) begin
         total++; if (if_id_valid_o !== 1'b1 || if_id_pc_o !== 64'h1004 || if_id_instr_o !== I1) begin
            bad++; $display("FAIL stall_hold[%0d] got=%b/%h/%h exp=1/1004/%h", k, if_id_valid_o, if_id_pc_o, if_id_instr_o, I1); end
         total++; if (imem_req_o !== 1'b0) begin bad++; $display("FAIL stall_req[%0d] got=%b exp=0", k, imem_req_o); end
         drive(1'b0, 1'b0, 32'h0, (k == 0), 1'b0, 64'h0);
         tick();
      end
      total++; if (if_id_valid_o !== 1'b1) begin bad++; $display("FAIL unstall_valid got=%b exp=1", if_id_valid_o); end
      total++; if (if_id_pc_o !== 64'h1008) begin bad++; $display("FAIL unstall_pc got=%h exp=1008", if_id_pc_o); end
      total++; if (if_id_instr_o !== I2) begin bad++; $display("FAIL unstall_instr got=%h exp=%h", if_id_instr_o, I2); end
      total++; if (imem_req_o !== 1'b1 || imem_addr_o !== 64'h100C) begin
         bad++; $display("FAIL unstall_req got=%b/%h exp=1/100c", imem_req_o, imem_addr_o); end
   endtask

   // Redirect while waiting: late response is drained, next fetch at aligned target.
   task automatic test_redirect_wait();
      drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
      tick();
      drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 64'h2002);
      tick();
      total++; if (imem_req_o !== 1'b0) begin bad++; $display("FAIL drain_req got=%b exp=0", imem_req_o); end
      total++; if (imem_addr_o !== 64'h2000) begin bad++; $display("FAIL drain_addr got=%h exp=2000", imem_addr_o); end
      drive(1'b0, 1'b1, BAD, 1'b0, 1'b0, 64'h0);
      tick();
      total++; if (if_id_valid_o !== 1'b0) begin bad++; $display("FAIL drain_discard got=%b exp=0", if_id_valid_o); end
      total++; if (imem_req_o !== 1'b1 || imem_addr_o !== 64'h2000) begin
         bad++; $display("FAIL redir_req got=%b/%h exp=1/2000", imem_req_o, imem_addr_o); end
      drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
      tick();
      drive(1'b0, 1'b1, I3, 1'b0, 1'b0, 64'h0);
      tick();
      total++; if (if_id_valid_o !== 1'b1 || if_id_pc_o !== 64'h2000 || if_id_instr_o !== I3) begin
         bad++; $display("FAIL redir_fetch got=%b/%h/%h exp=1/2000/%h", if_id_valid_o, if_id_pc_o, if_id_instr_o, I3); end
   endtask

   // Redirect coinciding with rvalid under stall: kill IF/ID, drop word, request target.
   task automatic test_redirect_rvalid_stall();
      drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 64'h0);
      tick();
      total++; if (if_id_valid_o !== 1'b1) begin bad++; $display("FAIL pre_kill_valid got=%b exp=1", if_id_valid_o); end
      drive(1'b0, 1'b1, BAD, 1'b1, 1'b1, 64'h3000);
      tick();
      total++; if (if_id_valid_o !== 1'b0) begin bad++; $display("FAIL kill_valid got=%b exp=0", if_id_valid_o); end
      total++; if (imem_req_o !== 1'b1 || imem_addr_o !== 64'h3000) begin
         bad++; $display("FAIL kill_req got=%b/%h exp=1/3000", imem_req_o, imem_addr_o); end
      drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
      tick();
      total++; if (imem_req_o !== 1'b1 || if_id_valid_o !== 1'b0) begin
         bad++; $display("FAIL kill_no_hold got=%b/%b exp=1/0", imem_req_o, if_id_valid_o); end
   endtask

   // Redirect from S_REQ without and with a same-cycle grant.
   task automatic test_redirect_req();
      drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 64'h4000);
      tick();
      total++; if (imem_req_o !== 1'b1 || imem_addr_o !== 64'h4000) begin
         bad++; $display("FAIL req_redir got=%b/%h exp=1/4000", imem_req_o, imem_addr_o); end
      drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 64'h5000);
      tick();
      total++; if (imem_req_o !== 1'b0 || imem_addr_o !== 64'h5000) begin
         bad++; $display("FAIL gnt_redir got=%b/%h exp=0/5000", imem_req_o, imem_addr_o); end
      drive(1'b0, 1'b1, BAD, 1'b0, 1'b0, 64'h0);
      tick();
      total++; if (imem_req_o !== 1'b1 || if_id_valid_o !== 1'b0) begin
         bad++; $display("FAIL gnt_redir_drain got=%b/%b exp=1/0", imem_req_o, if_id_valid_o); end
   endtask

   // PC increment wraps from the top of the address space to zero.
   task automatic test_wrap();
      drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
      tick();
      total++; if (imem_addr_o !== 64'hFFFF_FFFF_FFFF_FFFC) begin bad++; $display("FAIL wrap_start got=%h exp=fffffffffffffffc", imem_addr_o); end
      drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
      tick();
      drive(1'b0, 1'b1, I4, 1'b0, 1'b0, 64'h0);
      tick();
      total++; if (if_id_pc_o !== 64'hFFFF_FFFF_FFFF_FFFC || if_id_instr_o !== I4) begin
         bad++; $display("FAIL wrap_ifid got=%h/%h exp=fffffffffffffffc/%h", if_id_pc_o, if_id_instr_o, I4); end
      total++; if (imem_req_o !== 1'b1 || imem_addr_o !== 64'h0) begin
         bad++; $display("FAIL wrap_addr got=%b/%h exp=1/0", imem_req_o, imem_addr_o); end
   endtask

   // Asynchronous reset while a response is outstanding.
   task automatic test_reset_mid();
      drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
      tick();
      drive(1'b0, 1'b1, BAD, 1'b0, 1'b0, 64'h0);
      rst_n = 1'b0;
      #1;
      total++; if (imem_req_o !== 1'b0 || if_id_valid_o !== 1'b0) begin
         bad++; $display("FAIL mid_rst_ctl got=%b/%b exp=0/0", imem_req_o, if_id_valid_o); end
      total++; if (if_id_pc_o !== 64'h0 || if_id_instr_o !== NOP || imem_addr_o !== RST_PC) begin
         bad++; $display("FAIL mid_rst_data got=%h/%h/%h exp=0/%h/%h", if_id_pc_o, if_id_instr_o, imem_addr_o, NOP, RST_PC); end
      tick();
      drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
      rst_n = 1'b1;
      tick();
      total++; if (imem_req_o !== 1'b1 || imem_addr_o !== RST_PC || if_id_valid_o !== 1'b0) begin
         bad++; $display("FAIL mid_rst_restart got=%b/%h/%b exp=1/%h/0", imem_req_o, imem_addr_o, if_id_valid_o, RST_PC); end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_back_to_back();
      test_stall();
      test_redirect_wait();
      test_redirect_rvalid_stall();
      test_redirect_req();
      test_wrap();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
